// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I bundles into 32-bit words, range-checks every field,
// buffers legal words in a 2-entry FIFO and streams them to imem at incrementing addresses.
module instr_encoder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16:0]       in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [CNT_W-1:0]  count,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned OCC_W = 2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OPC   = 2'd1;
    localparam logic [1:0] ERR_IMM   = 2'd2;
    localparam logic [1:0] ERR_ALIGN = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic [ADDR_W-1:0]  addr;

    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic        imm_s12;
    logic        imm_s13;
    logic        imm_s21;
    logic [31:0] enc_word;
    logic [1:0]  enc_code;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;

    assign f7 = in_opcode[16:10];
    assign f3 = in_opcode[9:7];
    assign op = in_opcode[6:0];

    // Immediate fits a signed N-bit field when all bits above N-1 equal the sign bit
    assign imm_s12 = (&in_imm[31:11]) || (~|in_imm[31:11]);
    assign imm_s13 = (&in_imm[31:12]) || (~|in_imm[31:12]);
    assign imm_s21 = (&in_imm[31:20]) || (~|in_imm[31:20]);

    // Format-dependent packing and legality check, range errors outrank alignment errors
    always_comb begin
        enc_word = '0;
        enc_code = ERR_NONE;
        case (op)
            OP_R: enc_word = {f7, in_rs2, in_rs1, f3, in_rd, op};
            OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, op};
                    if (in_imm[31:5] != '0) begin
                        enc_code = ERR_IMM;
                    end else if (f3 == 3'b001 && f7 != 7'b0000000) begin
                        enc_code = ERR_IMM;
                    end else if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) begin
                        enc_code = ERR_IMM;
                    end
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, f3, in_rd, op};
                    if (!imm_s12) enc_code = ERR_IMM;
                end
            end
            OP_LOAD, OP_JALR: begin
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd, op};
                if (!imm_s12) enc_code = ERR_IMM;
            end
            OP_STORE: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], op};
                if (!imm_s12) enc_code = ERR_IMM;
            end
            OP_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], op};
                if (!imm_s13) enc_code = ERR_IMM;
                else if (in_imm[0]) enc_code = ERR_ALIGN;
            end
            OP_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
                if (!imm_s21) enc_code = ERR_IMM;
                else if (in_imm[0]) enc_code = ERR_ALIGN;
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {in_imm[31:12], in_rd, op};
                if (in_imm[11:0] != '0) enc_code = ERR_IMM;
            end
            default: enc_code = ERR_OPC;
        endcase
    end

    assign full       = (occ == OCC_W'(DEPTH));
    assign in_ready   = rst_n && !full && !start;
    assign accept     = in_valid && in_ready;
    assign push       = accept && (enc_code == ERR_NONE);
    assign mem_wvalid = (occ != '0);
    assign pop        = mem_wvalid && mem_wready;
    assign mem_waddr  = mem_wvalid ? fifo_q[rd_ptr].addr : '0;
    assign mem_wdata  = mem_wvalid ? fifo_q[rd_ptr].word : '0;

    // FIFO, address generator, write counter and sticky error state; start overrides all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= '0;
            addr     <= '0;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (start) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= '0;
            addr     <= base_addr;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{addr: addr, word: enc_word};
                wr_ptr         <= ~wr_ptr;
                addr           <= addr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (count != '1) count <= count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (accept && enc_code != ERR_NONE) begin
                err <= 1'b1;
                if (!err) err_code <= enc_code;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of encodings, directed FIFO/start/reset sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_instr_encoder;

    typedef struct packed {
        logic [16:0] op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } bun_t;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] w;
    } ent_t;

    typedef struct {
        bun_t        b;
        logic [31:0] word;
        logic [1:0]  code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [15:0] count;
    logic        err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .count(count), .err(err), .err_code(err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;

    ent_t        mq[$];
    ent_t        obs[$];
    logic [9:0]  m_addr;
    logic [15:0] m_cnt;
    logic        m_err;
    logic [1:0]  m_code;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bun_t mk(input logic [16:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm);
        bun_t b;
        b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
        return b;
    endfunction

    // Reference encoder written from the ISA field layout with shifts, masks and signed ranges
    function automatic void ref_enc(input bun_t b, output logic [31:0] w, output logic [1:0] code);
        bit [31:0] f7, f3, op, rd, rs1, rs2, im;
        int s;
        f7 = 32'(b.op[16:10]); f3 = 32'(b.op[9:7]); op = 32'(b.op[6:0]);
        rd = 32'(b.rd); rs1 = 32'(b.rs1); rs2 = 32'(b.rs2); im = b.imm;
        s = $signed(b.imm);
        w = 32'h0; code = 2'd0;
        if (op == 32'h33) begin
            w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        end else if (op == 32'h13 && (f3 == 1 || f3 == 5)) begin
            w = (f7 << 25) | ((im & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            if ((im >> 5) != 0) code = 2'd2;
            else if (f3 == 1 && f7 != 0) code = 2'd2;
            else if (f3 == 5 && f7 != 0 && f7 != 32) code = 2'd2;
        end else if (op == 32'h13 || op == 32'h03 || op == 32'h67) begin
            w = ((im & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            if (s < -2048 || s > 2047) code = 2'd2;
        end else if (op == 32'h23) begin
            w = (((im >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((im & 31) << 7) | op;
            if (s < -2048 || s > 2047) code = 2'd2;
        end else if (op == 32'h63) begin
            w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15) |
                (f3 << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | op;
            if (s < -4096 || s > 4095) code = 2'd2;
            else if ((im & 1) != 0) code = 2'd3;
        end else if (op == 32'h6F) begin
            w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20) |
                (((im >> 12) & 255) << 12) | (rd << 7) | op;
            if (s < -1048576 || s > 1048575) code = 2'd2;
            else if ((im & 1) != 0) code = 2'd3;
        end else if (op == 32'h37 || op == 32'h17) begin
            w = (im & 32'hFFFFF000) | (rd << 7) | op;
            if ((im & 32'hFFF) != 0) code = 2'd2;
        end else begin
            code = 2'd1;
        end
    endfunction

    task automatic check_state();
        chk("mem_wvalid", 64'(mem_wvalid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("mem_waddr", 64'(mem_waddr), 64'(mq[0].a));
            chk("mem_wdata", 64'(mem_wdata), 64'(mq[0].w));
        end
        chk("count", 64'(count), 64'(m_cnt));
        chk("err", 64'(err), 64'(m_err));
        chk("err_code", 64'(err_code), 64'(m_code));
    endtask

    // One clock: drive at the falling edge, advance the model, check state at the next falling edge
    task automatic cyc(input bun_t b, input logic v, input logic wr, input logic st,
                       input logic [9:0] base, output logic acc);
        logic        rdy;
        logic        macc;
        logic [31:0] w;
        logic [1:0]  c;
        ent_t        e;
        in_valid = v; in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
        in_imm = b.imm; mem_wready = wr; start = st; base_addr = base;
        rdy  = !st && (mq.size() < 2);
        macc = v && rdy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        acc = v && in_ready;
        if (mem_wvalid && wr) begin
            e.a = mem_waddr; e.w = mem_wdata;
            obs.push_back(e);
        end
        if (st) begin
            mq.delete(); m_addr = base; m_cnt = '0; m_err = 1'b0; m_code = 2'd0;
        end else begin
            if (mq.size() != 0 && wr) begin
                e = mq.pop_front();
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
            if (macc) begin
                ref_enc(b, w, c);
                if (c == 2'd0) begin
                    e.a = m_addr; e.w = w;
                    mq.push_back(e);
                    m_addr++;
                end else begin
                    if (!m_err) m_code = c;
                    m_err = 1'b1;
                end
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic idle(input int n, input logic wr);
        logic acc;
        for (int k = 0; k < n; k++) cyc(mk(17'h0, 5'd0, 5'd0, 5'd0, 32'h0), 1'b0, wr, 1'b0, 10'h0, acc);
    endtask

    task automatic do_start(input logic [9:0] base);
        logic acc;
        cyc(mk(17'h0, 5'd0, 5'd0, 5'd0, 32'h0), 1'b0, 1'b0, 1'b1, base, acc);
    endtask

    task automatic push(input bun_t b, input logic wr);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) cyc(b, 1'b1, wr, 1'b0, 10'h0, acc);
        chk("push_accepted", 64'(acc), 64'(1));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        in_valid = 1'b0; start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_wvalid", 64'(mem_wvalid), 64'(0));
        chk("rst_waddr", 64'(mem_waddr), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_err_code", 64'(err_code), 64'(0));
        mq.delete(); m_addr = '0; m_cnt = '0; m_err = 1'b0; m_code = 2'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_state();
    endtask

    vec_t vt[16];

    initial begin
        bun_t        b;
        logic        acc;
        logic [31:0] r;
        int          k;
        logic [6:0]  ops[9];

        vt[0]  = '{mk(17'h00033, 5'd3, 5'd1, 5'd2, 32'h0),        32'h002081B3, 2'd0};
        vt[1]  = '{mk(17'h08033, 5'd3, 5'd1, 5'd2, 32'h0),        32'h402081B3, 2'd0};
        vt[2]  = '{mk(17'h00123, 5'd31, 5'd1, 5'd2, 32'd12),      32'h0020A623, 2'd0};
        vt[3]  = '{mk(17'h00037, 5'd5, 5'd0, 5'd0, 32'h12345000), 32'h123452B7, 2'd0};
        vt[4]  = '{mk(17'h08293, 5'd4, 5'd1, 5'd0, 32'd3),        32'h4030D213, 2'd0};
        vt[5]  = '{mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF), 32'hFFF00093, 2'd0};
        vt[6]  = '{mk(17'h0006F, 5'd0, 5'd0, 5'd0, 32'h00000800), 32'h0010006F, 2'd0};
        vt[7]  = '{mk(17'h00037, 5'd5, 5'd0, 5'd0, 32'h12345001), 32'h0, 2'd2};
        vt[8]  = '{mk(17'h08093, 5'd1, 5'd1, 5'd0, 32'd1),        32'h0, 2'd2};
        vt[9]  = '{mk(17'h0006F, 5'd1, 5'd0, 5'd0, 32'h00100000), 32'h0, 2'd2};
        vt[10] = '{mk(17'h00063, 5'd0, 5'd1, 5'd2, 32'h00001001), 32'h0, 2'd2};
        vt[11] = '{mk(17'h00063, 5'd0, 5'd1, 5'd2, 32'd7),        32'h0, 2'd3};
        vt[12] = '{mk(17'h0007F, 5'd1, 5'd1, 5'd1, 32'h0),        32'h0, 2'd1};
        vt[13] = '{mk(17'h00093, 5'd1, 5'd1, 5'd0, 32'd32),       32'h0, 2'd2};
        vt[14] = '{mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd2047),     32'h7FF00093, 2'd0};
        vt[15] = '{mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'hFFFFF800), 32'h80000093, 2'd0};

        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};

        rst_n = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_opcode = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; mem_wready = 1'b0;
        do_reset();

        // ADDI, JAL, BEQ written at consecutive addresses from base 0x010
        obs.delete();
        do_start(10'h010);
        push(mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd5), 1'b1);
        idle(2, 1'b1);
        push(mk(17'h0006F, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC), 1'b1);
        push(mk(17'h00063, 5'd0, 5'd1, 5'd2, 32'd8), 1'b1);
        idle(3, 1'b1);
        chk("t1_writes", 64'(obs.size()), 64'(3));
        if (obs.size() == 3) begin
            chk("t1_addi", 64'(obs[0]), {22'h0, 10'h010, 32'h00500093});
            chk("t2_jal", 64'(obs[1]), {22'h0, 10'h011, 32'hFFDFF0EF});
            chk("t2_beq", 64'(obs[2]), {22'h0, 10'h012, 32'h00208463});
        end

        // Backpressure: third bundle stalls until the FIFO drains
        obs.delete();
        do_start(10'h040);
        push(mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd1), 1'b0);
        push(mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd2), 1'b0);
        chk("t3_full_ready", 64'(in_ready), 64'(0));
        cyc(mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd3), 1'b1, 1'b0, 1'b0, 10'h0, acc);
        chk("t3_stalled", 64'(acc), 64'(0));
        push(mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd3), 1'b1);
        idle(4, 1'b1);
        chk("t3_writes", 64'(obs.size()), 64'(3));
        if (obs.size() == 3) begin
            chk("t3_w0", 64'(obs[0]), {22'h0, 10'h040, 32'h00100093});
            chk("t3_w1", 64'(obs[1]), {22'h0, 10'h041, 32'h00200093});
            chk("t3_w2", 64'(obs[2]), {22'h0, 10'h042, 32'h00300093});
        end
        chk("t3_count", 64'(count), 64'(3));

        // First error is kept; a later misaligned branch does not overwrite it
        obs.delete();
        do_start(10'h020);
        push(mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd2048), 1'b1);
        idle(2, 1'b1);
        chk("t4_nowrite", 64'(obs.size()), 64'(0));
        chk("t4_err", 64'(err), 64'(1));
        chk("t4_code", 64'(err_code), 64'(2));
        push(mk(17'h00063, 5'd0, 5'd1, 5'd2, 32'd7), 1'b1);
        idle(2, 1'b1);
        chk("t4_nowrite2", 64'(obs.size()), 64'(0));
        chk("t4_code_held", 64'(err_code), 64'(2));
        do_start(10'h020);
        chk("t4_err_cleared", 64'(err), 64'(0));

        // Address wrap and illegal opcode leaving the address untouched
        obs.delete();
        do_start(10'h3FF);
        push(mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd1), 1'b1);
        push(mk(17'h00013, 5'd2, 5'd0, 5'd0, 32'd2), 1'b1);
        idle(3, 1'b1);
        push(mk(17'h0007F, 5'd1, 5'd0, 5'd0, 32'd0), 1'b1);
        idle(1, 1'b1);
        chk("t5_code", 64'(err_code), 64'(1));
        push(mk(17'h00013, 5'd3, 5'd0, 5'd0, 32'd3), 1'b1);
        idle(2, 1'b1);
        chk("t5_writes", 64'(obs.size()), 64'(3));
        if (obs.size() == 3) begin
            chk("t5_a0", 64'(obs[0].a), 64'(10'h3FF));
            chk("t5_a1", 64'(obs[1].a), 64'(10'h000));
            chk("t5_a2", 64'(obs[2].a), 64'(10'h001));
        end

        // start discards queued entries
        do_start(10'h050);
        push(mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd1), 1'b0);
        push(mk(17'h00013, 5'd2, 5'd0, 5'd0, 32'd2), 1'b0);
        obs.delete();
        do_start(10'h080);
        idle(3, 1'b1);
        chk("t6_flush_nowrite", 64'(obs.size()), 64'(0));
        push(mk(17'h00013, 5'd4, 5'd0, 5'd0, 32'd4), 1'b1);
        idle(2, 1'b1);
        chk("t6_after_start", 64'(obs.size()), 64'(1));
        if (obs.size() == 1) chk("t6_addr_base", 64'(obs[0].a), 64'(10'h080));

        // Reset discards queued entries
        push(mk(17'h00013, 5'd1, 5'd0, 5'd0, 32'd1), 1'b0);
        push(mk(17'h00013, 5'd2, 5'd0, 5'd0, 32'd2), 1'b0);
        obs.delete();
        do_reset();
        idle(3, 1'b1);
        chk("t6_reset_nowrite", 64'(obs.size()), 64'(0));
        push(mk(17'h00013, 5'd5, 5'd0, 5'd0, 32'd5), 1'b1);
        idle(2, 1'b1);
        chk("t6_after_reset", 64'(obs.size()), 64'(1));
        if (obs.size() == 1) chk("t6_addr_zero", 64'(obs[0].a), 64'(10'h000));

        // Encoding table
        for (int i = 0; i < 16; i++) begin
            do_start(10'(10'h100 + i));
            obs.delete();
            push(vt[i].b, 1'b1);
            idle(2, 1'b1);
            if (vt[i].code == 2'd0) begin
                chk($sformatf("vec%0d_writes", i), 64'(obs.size()), 64'(1));
                if (obs.size() == 1) begin
                    chk($sformatf("vec%0d_word", i), 64'(obs[0].w), 64'(vt[i].word));
                    chk($sformatf("vec%0d_addr", i), 64'(obs[0].a), 64'(10'h100 + i));
                end
                chk($sformatf("vec%0d_err", i), 64'(err), 64'(0));
            end else begin
                chk($sformatf("vec%0d_nowrite", i), 64'(obs.size()), 64'(0));
                chk($sformatf("vec%0d_code", i), 64'(err_code), 64'(vt[i].code));
            end
        end

        // Randomized traffic against the reference model
        do_start(10'(10'h3F0));
        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 10);
            b.op[6:0]   = (k < 9) ? ops[k] : 7'($urandom);
            b.op[9:7]   = 3'($urandom);
            b.op[16:10] = ($urandom_range(0, 3) == 0) ? 7'($urandom) :
                          (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
            b.rd  = 5'($urandom);
            b.rs1 = 5'($urandom);
            b.rs2 = 5'($urandom);
            r = $urandom;
            case ($urandom_range(0, 4))
                0:       b.imm = r;
                1:       b.imm = 32'($signed(12'(r)));
                2:       b.imm = 32'($signed(14'(r))) & 32'hFFFFFFFE;
                3:       b.imm = 32'($signed(22'(r)));
                default: b.imm = {r[19:0], 12'h000};
            endcase
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc(b, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                    $urandom_range(0, 99) == 0, 10'($urandom), acc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
